// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPARE  = 3'd1,
    MEM_RD   = 3'd2,
    MEM_FILL = 3'd3,
    MEM_WR   = 3'd4
  } state_t;

  // Lines are a power of two, so modulo/divide reduce to the low/high address bits.
  function automatic int unsigned get_idx(input int unsigned addr, input int unsigned lines);
    return addr % lines;
  endfunction

  function automatic int unsigned get_tag(input int unsigned addr, input int unsigned lines);
    return addr / lines;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for a direct-mapped cache: combinational lookup, one write port.
import cache_pkg::*;

module cache_line_store #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LINES  = 16,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  lk_idx,
  input  logic [TAG_W-1:0]  lk_tag,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] lines [LINES];

  // Only the valid bits are cleared; stale tags/data are harmless while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_data;
    end
  end

  assign lk_hit  = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign lk_data = lines[lk_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller in front of a 1-cycle sync RAM.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
import cache_pkg::*;

module dm_cache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_t state, state_nxt;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [IDX_W-1:0]  lat_idx;
  logic [TAG_W-1:0]  lat_tag;
  logic              hit;
  logic [DATA_W-1:0] line_data;
  logic              ls_wr_en;
  logic [DATA_W-1:0] ls_wr_data;

  assign lat_idx = IDX_W'(get_idx(32'(lat_addr), LINES));
  assign lat_tag = TAG_W'(get_tag(32'(lat_addr), LINES));

  cache_line_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .lk_idx  (lat_idx),
    .lk_tag  (lat_tag),
    .lk_hit  (hit),
    .lk_data (line_data),
    .wr_en   (ls_wr_en),
    .wr_idx  (lat_idx),
    .wr_tag  (lat_tag),
    .wr_data (ls_wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid) state_nxt = COMPARE;
      COMPARE: begin
        if (lat_we)   state_nxt = MEM_WR;
        else if (hit) state_nxt = IDLE;
        else          state_nxt = MEM_RD;
      end
      MEM_RD:   state_nxt = MEM_FILL;
      MEM_FILL: state_nxt = IDLE;
      MEM_WR:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // RAM port and line-store write are pure decodes of state and the latched request.
  always_comb begin
    req_ready  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ls_wr_en   = 1'b0;
    ls_wr_data = '0;
    case (state)
      IDLE:     req_ready = 1'b1;
      MEM_RD:   mem_addr  = lat_addr;
      MEM_FILL: begin
        ls_wr_en   = 1'b1;
        ls_wr_data = mem_rdata;
      end
      MEM_WR: begin
        mem_we     = 1'b1;
        mem_addr   = lat_addr;
        mem_wdata  = lat_wdata;
        ls_wr_en   = hit;
        ls_wr_data = lat_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && req_valid) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Response: one-cycle pulse, data held between loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        COMPARE: begin
          if (!lat_we && hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= line_data;
          end
        end
        MEM_FILL: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_rdata;
        end
        MEM_WR:  rsp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == COMPARE && !lat_we) begin
      if (hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      else if (!hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
